// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings and helpers for the tagged register-load bus
package wb_pkg;

   localparam int DATA_W = 4;
   localparam int BUS_W  = 5;

   // NULL carries bit4=1; every valid load word has bit4=0 so the two never alias
   localparam logic [BUS_W-1:0] WB_NULL = 5'b10000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      STALL = 2'd2
   } wb_state_t;

   function automatic logic [BUS_W-1:0] wb_word(input logic [DATA_W-1:0] data);
      return {1'b0, data};
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry queue of {dest,data} write-back requests
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DEST_W = 2
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   Flush,
   input  logic                   wr_en,
   input  logic [DEST_W-1:0]      wr_dest,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   rd_en,
   output logic [DEST_W-1:0]      rd_dest,
   output logic [DATA_W-1:0]      rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEST_W+DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic                     do_wr;
   logic                     do_rd;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // full blocks writes regardless of a same-cycle read: no pass-through
   assign do_wr = wr_en && !full && !Flush && !Reset;
   assign do_rd = rd_en && !empty;

   assign {rd_dest, rd_data} = mem[rd_ptr];

   always_ff @(posedge Clock) begin
      if (do_wr) begin
         mem[wr_ptr] <= {wr_dest, wr_data};
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset || Flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_bus_driver.sv
// rtl/wb_bus_driver.sv - queues write-backs and drives one tagged load word per Clock
module wb_bus_driver
   import wb_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int NUM_REGS = 4,
   parameter int DEST_W   = 2
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   Flush,
   input  logic                   push_valid,
   input  logic [DATA_W-1:0]      push_data,
   input  logic [DEST_W-1:0]      push_dest,
   output logic                   push_ready,
   input  logic                   hold,
   output logic [BUS_W-1:0]       bus_D,
   output logic [NUM_REGS-1:0]    reg_enable,
   output logic [$clog2(DEPTH):0] count,
   output logic                   busy
);

   wb_state_t             state;
   wb_state_t             state_nxt;
   logic                  dest_ok;
   logic                  push_fire;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DEST_W-1:0]     head_dest;
   logic [DATA_W-1:0]     head_data;
   logic [BUS_W-1:0]      bus_nxt;
   logic [NUM_REGS-1:0]   enable_nxt;

   // a non-power-of-2 register count leaves unreachable indices that must be dropped
   generate
      if ((1 << DEST_W) == NUM_REGS) begin : g_full_range
         assign dest_ok = 1'b1;
      end else begin : g_range_chk
         assign dest_ok = (int'(push_dest) < NUM_REGS);
      end
   endgenerate

   assign push_ready = !fifo_full;
   assign push_fire  = push_valid && push_ready && dest_ok && !Flush;
   assign pop        = !fifo_empty && !hold && !Flush;

   wb_fifo #(
      .DEPTH  (DEPTH),
      .DEST_W (DEST_W)
   ) u_fifo (
      .Clock   (Clock),
      .Reset   (Reset),
      .Flush   (Flush),
      .wr_en   (push_fire),
      .wr_dest (push_dest),
      .wr_data (push_data),
      .rd_en   (pop),
      .rd_dest (head_dest),
      .rd_data (head_data),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_nxt  = state;
      bus_nxt    = WB_NULL;
      enable_nxt = '0;

      case (state)
         IDLE: begin
            if (pop) begin
               state_nxt = SEND;
            end else if (!fifo_empty) begin
               state_nxt = STALL;
            end
         end
         SEND: begin
            if (!pop) begin
               state_nxt = fifo_empty ? IDLE : STALL;
            end
         end
         STALL: begin
            if (pop) begin
               state_nxt = SEND;
            end else if (fifo_empty) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (Flush) begin
         state_nxt = IDLE;
      end

      if (pop) begin
         bus_nxt    = wb_word(head_data);
         enable_nxt = NUM_REGS'(1) << head_dest;
      end
   end

   // bus and enables are registered so each valid word lives exactly one cycle
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= IDLE;
         bus_D      <= WB_NULL;
         reg_enable <= '0;
      end else begin
         state      <= state_nxt;
         bus_D      <= bus_nxt;
         reg_enable <= enable_nxt;
      end
   end

   assign busy = (count != '0) || (bus_D != WB_NULL);

endmodule

// File: tb/tb_wb_bus_driver.sv
// tb/tb_wb_bus_driver.sv - directed self-checking bench for wb_bus_driver
module tb_wb_bus_driver;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       Flush;
   logic       push_valid;
   logic [3:0] push_data;
   logic [1:0] push_dest;
   logic       push_ready;
   logic       hold;
   logic [4:0] bus_D;
   logic [3:0] reg_enable;
   logic [2:0] count;
   logic       busy;

   int errors = 0;
   int checks = 0;

   wb_bus_driver #(
      .DEPTH    (4),
      .NUM_REGS (4),
      .DEST_W   (2)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Flush      (Flush),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_dest  (push_dest),
      .push_ready (push_ready),
      .hold       (hold),
      .bus_D      (bus_D),
      .reg_enable (reg_enable),
      .count      (count),
      .busy       (busy)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(negedge Clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [4:0] e_bus, input logic [3:0] e_en,
                          input logic [2:0] e_cnt);
      chk({tag, ".bus_D"}, 32'(bus_D), 32'(e_bus));
      chk({tag, ".reg_enable"}, 32'(reg_enable), 32'(e_en));
      chk({tag, ".count"}, 32'(count), 32'(e_cnt));
   endtask

   task automatic push(input logic [3:0] d, input logic [1:0] dst);
      push_valid = 1'b1;
      push_data  = d;
      push_dest  = dst;
   endtask

   initial begin
      Reset = 1'b1; Flush = 1'b0; push_valid = 1'b0; push_data = '0; push_dest = '0; hold = 1'b0;
      tick(); tick();
      Reset = 1'b0;
      tick();
      chk_out("reset", 5'h10, 4'b0000, 3'd0);
      chk("reset.push_ready", 32'(push_ready), 32'd1);
      chk("reset.busy", 32'(busy), 32'd0);

      // 1: reset with three queued entries, hold dropped in the same cycle
      hold = 1'b1;
      push(4'h1, 2'd1); tick();
      push(4'h2, 2'd2); tick();
      push(4'h3, 2'd3); tick();
      push_valid = 1'b0;
      chk_out("t1.queued", 5'h10, 4'b0000, 3'd3);
      chk("t1.busy", 32'(busy), 32'd1);
      Reset = 1'b1; hold = 1'b0;
      tick();
      chk_out("t1.reset", 5'h10, 4'b0000, 3'd0);
      chk("t1.push_ready", 32'(push_ready), 32'd1);
      Reset = 1'b0;
      tick();
      chk_out("t1.after", 5'h10, 4'b0000, 3'd0);

      // 2: single push, one-cycle latency, one-cycle word
      push(4'hA, 2'd2); tick();
      push_valid = 1'b0;
      chk_out("t2.pushed", 5'h10, 4'b0000, 3'd1);
      tick();
      chk_out("t2.word", 5'b01010, 4'b0100, 3'd0);
      tick();
      chk_out("t2.null", 5'h10, 4'b0000, 3'd0);

      // 3: five pushes under hold, only four fit
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push(4'(i + 1), 2'(i));
         chk($sformatf("t3.push_ready%0d", i), 32'(push_ready), (i < 4) ? 32'd1 : 32'd0);
         tick();
      end
      push_valid = 1'b0;
      chk_out("t3.full", 5'h10, 4'b0000, 3'd4);

      // 4: release hold, drain in push order
      hold = 1'b0;
      tick(); chk_out("t4.w0", 5'h01, 4'b0001, 3'd3);
      tick(); chk_out("t4.w1", 5'h02, 4'b0010, 3'd2);
      tick(); chk_out("t4.w2", 5'h03, 4'b0100, 3'd1);
      tick(); chk_out("t4.w3", 5'h04, 4'b1000, 3'd0);
      tick(); chk_out("t4.null", 5'h10, 4'b0000, 3'd0);
      chk("t4.busy", 32'(busy), 32'd0);

      // 5: zero data is a valid word, not NULL
      push(4'h0, 2'd0); tick();
      push_valid = 1'b0;
      tick();
      chk_out("t5.word", 5'b00000, 4'b0001, 3'd0);
      chk("t5.busy", 32'(busy), 32'd1);
      tick();
      chk_out("t5.null", 5'h10, 4'b0000, 3'd0);

      // 6: flush with three queued and a push in the flush cycle
      hold = 1'b1;
      push(4'h7, 2'd0); tick();
      push(4'h8, 2'd1); tick();
      push(4'h9, 2'd2); tick();
      chk_out("t6.queued", 5'h10, 4'b0000, 3'd3);
      Flush = 1'b1; hold = 1'b0; push(4'hF, 2'd3);
      tick();
      chk_out("t6.flush", 5'h10, 4'b0000, 3'd0);
      Flush = 1'b0; push_valid = 1'b0;
      tick(); chk_out("t6.after0", 5'h10, 4'b0000, 3'd0);
      tick(); chk_out("t6.after1", 5'h10, 4'b0000, 3'd0);

      // 7: simultaneous push and pop keeps count and order
      push(4'h5, 2'd1); tick();
      chk_out("t7.first", 5'h10, 4'b0000, 3'd1);
      push(4'h6, 2'd3); tick();
      chk_out("t7.overlap", 5'h05, 4'b0010, 3'd1);
      push_valid = 1'b0; tick();
      chk_out("t7.second", 5'h06, 4'b1000, 3'd0);
      tick();

      // 8: full queue rejects a push even while popping
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(4'(8 + i), 2'(i)); tick();
      end
      hold = 1'b0; push(4'hE, 2'd0);
      chk("t8.push_ready", 32'(push_ready), 32'd0);
      tick();
      push_valid = 1'b0;
      chk_out("t8.pop", 5'h08, 4'b0001, 3'd3);
      tick(); chk_out("t8.w1", 5'h09, 4'b0010, 3'd2);
      tick(); chk_out("t8.w2", 5'h0A, 4'b0100, 3'd1);
      tick(); chk_out("t8.w3", 5'h0B, 4'b1000, 3'd0);
      tick(); chk_out("t8.null", 5'h10, 4'b0000, 3'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
